// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad capture block: key codes, FSM state
// types and the row/column to key-code mapping.
package keypad_pkg;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        SC_SCAN        = 2'd0,
        SC_DEB_PRESS   = 2'd1,
        SC_HELD        = 2'd2,
        SC_DEB_RELEASE = 2'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        CAP_ENTER_A = 2'd0,
        CAP_ENTER_B = 2'd1,
        CAP_DONE    = 2'd2
    } cap_state_t;

    // Row 0 is the top row of the keypad, column 0 the leftmost.
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = KEY_A;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = KEY_B;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = KEY_C;
            4'd12:   code = KEY_STAR;
            4'd13:   code = 4'd0;
            4'd14:   code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    // Rows are active-low; when several are low the lowest index wins.
    function automatic logic [1:0] first_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner and debouncer for a 4x4 active-low matrix keypad.
//
//   state          | meaning
//   SC_SCAN        | rotating column drive, looking for any low row
//   SC_DEB_PRESS   | column frozen, row pattern must stay stable to accept
//   SC_HELD        | key accepted, waiting for all rows to go high
//   SC_DEB_RELEASE | rows high, must stay high before scanning resumes
//
// The synchronized rows lag the column drive by two clocks, so a low row is
// only trusted when the sample was taken under the column that is driven
// now. This leaves SCAN_COUNT-2 usable cycles per column window.
module keypad_scan #(
    parameter int SCAN_COUNT     = 1000,
    parameter int DEBOUNCE_COUNT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o
);
    import keypad_pkg::*;

    localparam int SCAN_W = (SCAN_COUNT > 2) ? $clog2(SCAN_COUNT) : 1;
    localparam int DEB_W  = (DEBOUNCE_COUNT > 2) ? $clog2(DEBOUNCE_COUNT - 1) : 1;

    // The sample that triggers a transition counts as the first stable cycle.
    localparam logic [SCAN_W-1:0] SCAN_RELOAD = SCAN_W'(SCAN_COUNT - 1);
    localparam logic [DEB_W-1:0]  DEB_RELOAD  = DEB_W'(DEBOUNCE_COUNT - 2);

    scan_state_t       state_q, state_d;
    logic [3:0]        rows_m_q, rows_s_q;
    logic [1:0]        colp1_q, colp2_q;
    logic [1:0]        col_q, col_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]        latch_q, latch_d;
    logic              key_valid_q, key_valid_d;
    logic [3:0]        key_code_q, key_code_d;

    logic sample_ok, press_seen, same_pat, all_up, deb_tc, scan_tc;

    assign sample_ok  = (colp2_q == col_q);
    assign press_seen = (rows_s_q != 4'hF);
    assign same_pat   = (rows_s_q == latch_q);
    assign all_up     = (rows_s_q == 4'hF);
    assign deb_tc     = (deb_cnt_q == '0);
    assign scan_tc    = (scan_cnt_q == '0);

    // Two-flop row synchronizer, with the driven column tracked alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_m_q <= 4'hF;
            rows_s_q <= 4'hF;
            colp1_q  <= 2'd0;
            colp2_q  <= 2'd0;
        end else begin
            rows_m_q <= row_i;
            rows_s_q <= rows_m_q;
            colp1_q  <= col_q;
            colp2_q  <= colp1_q;
        end
    end

    // Scanner state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SC_SCAN;
        else        state_q <= state_d;
    end

    // Scanner next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SC_SCAN:        if (sample_ok && press_seen) state_d = SC_DEB_PRESS;
            SC_DEB_PRESS:   if (!same_pat)               state_d = SC_SCAN;
                            else if (deb_tc)             state_d = SC_HELD;
            SC_HELD:        if (all_up)                  state_d = SC_DEB_RELEASE;
            SC_DEB_RELEASE: if (!all_up)                 state_d = SC_HELD;
                            else if (deb_tc)             state_d = SC_SCAN;
            default:                                     state_d = SC_SCAN;
        endcase
    end

    // Column, timers, latched pattern and key event generation.
    always_comb begin
        col_d       = col_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        latch_d     = latch_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        case (state_q)
            SC_SCAN: begin
                if (sample_ok && press_seen) begin
                    latch_d   = rows_s_q;
                    deb_cnt_d = DEB_RELOAD;
                end else if (scan_tc) begin
                    col_d      = col_q + 2'd1;
                    scan_cnt_d = SCAN_RELOAD;
                end else begin
                    scan_cnt_d = scan_cnt_q - SCAN_W'(1);
                end
            end
            SC_DEB_PRESS: begin
                if (!same_pat) begin
                    scan_cnt_d = SCAN_RELOAD;
                end else if (deb_tc) begin
                    key_valid_d = 1'b1;
                    key_code_d  = key_lookup(first_low_row(latch_q), col_q);
                end else begin
                    deb_cnt_d = deb_cnt_q - DEB_W'(1);
                end
            end
            SC_HELD: begin
                if (all_up) deb_cnt_d = DEB_RELOAD;
            end
            SC_DEB_RELEASE: begin
                if (all_up) begin
                    if (deb_tc) begin
                        col_d      = col_q + 2'd1;
                        scan_cnt_d = SCAN_RELOAD;
                    end else begin
                        deb_cnt_d = deb_cnt_q - DEB_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Scanner datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= 2'd0;
            scan_cnt_q  <= SCAN_RELOAD;
            deb_cnt_q   <= DEB_RELOAD;
            latch_q     <= 4'hF;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            col_q       <= col_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            latch_q     <= latch_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    // One-hot active-low column drive and key event outputs.
    always_comb begin
        col_o       = ~(4'b0001 << col_q);
        key_valid_o = key_valid_q;
        key_code_o  = key_code_q;
    end

endmodule

// File: rtl/keypad_capture.sv
// Keypad front end that assembles two 3-digit BCD operands from key presses.
//
//   state       | meaning
//   CAP_ENTER_A | digits shift into operand 1, A moves on to operand 2
//   CAP_ENTER_B | digits shift into operand 2, # commits both operands
//   CAP_DONE    | both operands committed, a digit starts a fresh entry
//
// * clears everything from any state.
module keypad_capture #(
    parameter int SCAN_COUNT     = 1000,
    parameter int DEBOUNCE_COUNT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] dig1_1,
    output logic [3:0] dig1_2,
    output logic [3:0] dig1_3,
    output logic [3:0] dig2_1,
    output logic [3:0] dig2_2,
    output logic [3:0] dig2_3,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       operand_sel,
    output logic       result_valid
);
    import keypad_pkg::*;

    logic       kv;
    logic [3:0] kc;

    cap_state_t  state_q, state_d;
    logic [11:0] op1_q, op1_d;
    logic [11:0] op2_q, op2_d;
    logic [1:0]  cnt1_q, cnt1_d;
    logic [1:0]  cnt2_q, cnt2_d;

    keypad_scan #(
        .SCAN_COUNT    (SCAN_COUNT),
        .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_i      (row_in),
        .col_o      (col_out),
        .key_valid_o(kv),
        .key_code_o (kc)
    );

    // Capture state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CAP_ENTER_A;
        else        state_q <= state_d;
    end

    // Capture next-state logic, advancing only on accepted keys.
    always_comb begin
        state_d = state_q;
        if (kv) begin
            case (state_q)
                CAP_ENTER_A: begin
                    if (kc == KEY_A)         state_d = CAP_ENTER_B;
                    else if (kc == KEY_STAR) state_d = CAP_ENTER_A;
                end
                CAP_ENTER_B: begin
                    if (kc == KEY_HASH)      state_d = CAP_DONE;
                    else if (kc == KEY_STAR) state_d = CAP_ENTER_A;
                end
                CAP_DONE: begin
                    if (is_digit(kc) || kc == KEY_STAR) state_d = CAP_ENTER_A;
                end
                default: state_d = CAP_ENTER_A;
            endcase
        end
    end

    // Operand shift registers and digit counters; a full operand ignores digits.
    always_comb begin
        op1_d  = op1_q;
        op2_d  = op2_q;
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (kv) begin
            if (kc == KEY_STAR) begin
                op1_d  = '0;
                op2_d  = '0;
                cnt1_d = 2'd0;
                cnt2_d = 2'd0;
            end else if (is_digit(kc)) begin
                case (state_q)
                    CAP_ENTER_A: begin
                        if (cnt1_q != 2'd3) begin
                            op1_d  = {op1_q[7:0], kc};
                            cnt1_d = cnt1_q + 2'd1;
                        end
                    end
                    CAP_ENTER_B: begin
                        if (cnt2_q != 2'd3) begin
                            op2_d  = {op2_q[7:0], kc};
                            cnt2_d = cnt2_q + 2'd1;
                        end
                    end
                    CAP_DONE: begin
                        op1_d  = {8'h00, kc};
                        op2_d  = '0;
                        cnt1_d = 2'd1;
                        cnt2_d = 2'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q  <= '0;
            op2_q  <= '0;
            cnt1_q <= 2'd0;
            cnt2_q <= 2'd0;
        end else begin
            op1_q  <= op1_d;
            op2_q  <= op2_d;
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    // Outputs decoded from the capture state and operand registers.
    always_comb begin
        operand_sel  = (state_q != CAP_ENTER_A);
        result_valid = (state_q == CAP_DONE);
        dig1_1       = op1_q[3:0];
        dig1_2       = op1_q[7:4];
        dig1_3       = op1_q[11:8];
        dig2_1       = op2_q[3:0];
        dig2_2       = op2_q[7:4];
        dig2_3       = op2_q[11:8];
        key_valid    = kv;
        key_code     = kc;
    end

endmodule

// File: tb/tb_keypad_capture.sv
// Bench for keypad_capture with a switch-matrix keypad model and an
// arithmetic model of operand entry.
module tb_keypad_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3;
    logic       key_valid;
    logic [3:0] key_code;
    logic       operand_sel, result_valid;

    logic [15:0] keys = 16'h0;   // bit r*4+c: key at row r, column c is closed
    int total = 0;
    int bad = 0;
    int kv_cnt = 0;

    // Model of entry: operands as plain integers with digit counts.
    int m_v1 = 0, m_v2 = 0, m_n1 = 0, m_n2 = 0, m_ph = 0;

    int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    keypad_capture #(.SCAN_COUNT(4), .DEBOUNCE_COUNT(8)) dut (
        .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
        .dig1_1(dig1_1), .dig1_2(dig1_2), .dig1_3(dig1_3),
        .dig2_1(dig2_1), .dig2_2(dig2_2), .dig2_3(dig2_3),
        .key_valid(key_valid), .key_code(key_code),
        .operand_sel(operand_sel), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    always @(negedge clk) if (key_valid === 1'b1) kv_cnt++;

    wire [25:0] obs = {dig1_3, dig1_2, dig1_1, dig2_3, dig2_2, dig2_1, operand_sel, result_valid};

    function automatic logic [25:0] model_vec();
        return {4'(m_v1 / 100), 4'((m_v1 / 10) % 10), 4'(m_v1 % 10),
                4'(m_v2 / 100), 4'((m_v2 / 10) % 10), 4'(m_v2 % 10),
                (m_ph != 0), (m_ph == 2)};
    endfunction

    task automatic model_clear();
        m_v1 = 0; m_v2 = 0; m_n1 = 0; m_n2 = 0; m_ph = 0;
    endtask

    task automatic model_key(input int code);
        if (code == 14) model_clear();
        else if (m_ph == 0) begin
            if (code <= 9 && m_n1 < 3) begin m_v1 = m_v1 * 10 + code; m_n1++; end
            else if (code == 10) m_ph = 1;
        end else if (m_ph == 1) begin
            if (code <= 9 && m_n2 < 3) begin m_v2 = m_v2 * 10 + code; m_n2++; end
            else if (code == 15) m_ph = 2;
        end else if (code <= 9) begin
            model_clear(); m_v1 = code; m_n1 = 1;
        end
    endtask

    function automatic int key_pos(input int code);
        for (int i = 0; i < 16; i++) if (keymap[i] == code) return i;
        return 0;
    endfunction

    // Close a key until it is accepted (bounded), hold, release, let it settle.
    task automatic press_key(input int code, input int hold, output bit got, output logic [3:0] kc);
        int idx;
        idx = key_pos(code);
        got = 1'b0;
        kc  = 4'hx;
        keys[idx] = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin got = 1'b1; kc = key_code; end
        end
        repeat (hold) @(negedge clk);
        keys[idx] = 1'b0;
        repeat (30) @(negedge clk);
        model_key(code);
    endtask

    // Wait for the start of a column-0 window.
    task automatic wait_col0_start(output bit ok);
        int n;
        n = 0;
        while (col_out == 4'b1110 && n < 50) begin @(negedge clk); n++; end
        while (col_out != 4'b1110 && n < 50) begin @(negedge clk); n++; end
        ok = (n < 50);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (obs !== 26'd0 || key_valid !== 1'b0 || key_code !== 4'd0) begin
            bad++; $display("FAIL reset_outputs: got %h/%b/%h required 0/0/0", obs, key_valid, key_code);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] exp_col;
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            total++;
            if (col_out !== exp_col) begin
                bad++; $display("FAIL col_rotate[%0d]: got %b required %b", i, col_out, exp_col);
            end
            @(negedge clk);
        end
        total++;
        if (kv_cnt != 0) begin bad++; $display("FAIL idle_no_key: got %0d pulses required 0", kv_cnt); end
    endtask

    task automatic test_single_key();
        int kv0;
        bit got, frozen;
        kv0 = kv_cnt;
        got = 1'b0;
        keys[5] = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) got = 1'b1;
        end
        total++;
        if (!got || key_code !== 4'd5) begin
            bad++; $display("FAIL key5_accept: got valid=%b code=%h required valid=1 code=5", got, key_code);
        end
        frozen = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (col_out !== 4'b1101) frozen = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!frozen) begin bad++; $display("FAIL key5_col_frozen: got %b required 1101", col_out); end
        keys[5] = 1'b0;
        repeat (9) @(negedge clk);
        total++;
        if (col_out !== 4'b1101) begin bad++; $display("FAIL release_hold_col: got %b required 1101", col_out); end
        @(negedge clk);
        total++;
        if (col_out !== 4'b1011) begin bad++; $display("FAIL release_next_col: got %b required 1011", col_out); end
        repeat (20) @(negedge clk);
        model_key(5);
        total++;
        if (kv_cnt - kv0 != 1) begin bad++; $display("FAIL key5_one_pulse: got %0d required 1", kv_cnt - kv0); end
        total++;
        if (dig1_1 !== 4'd5 || obs !== model_vec()) begin
            bad++; $display("FAIL key5_digits: got %h required %h", obs, model_vec());
        end
    endtask

    task automatic test_sequence();
        int seq [10] = '{14, 1, 2, 3, 4, 10, 4, 5, 6, 15};
        bit got;
        logic [3:0] kc;
        for (int i = 0; i < 10; i++) begin
            press_key(seq[i], 3, got, kc);
            total++;
            if (!got || kc !== 4'(seq[i])) begin
                bad++; $display("FAIL seq_key[%0d]: got valid=%b code=%h required code=%0d", i, got, kc, seq[i]);
            end
        end
        total++;
        if (obs !== {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1'b1, 1'b1} || obs !== model_vec()) begin
            bad++; $display("FAIL seq_operands: got %h required %h", obs, {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 2'b11});
        end
    endtask

    task automatic test_bounce();
        int kv0;
        bit ok;
        kv0 = kv_cnt;
        wait_col0_start(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bounce_col_wait: got timeout required column 0"); end
        keys[8] = 1'b1; repeat (3)  @(negedge clk);
        keys[8] = 1'b0; repeat (2)  @(negedge clk);
        keys[8] = 1'b1; repeat (10) @(negedge clk);
        keys[8] = 1'b0; repeat (40) @(negedge clk);
        model_key(7);
        total++;
        if (kv_cnt - kv0 != 1 || key_code !== 4'd7) begin
            bad++; $display("FAIL bounce_one_key: got %0d pulses code=%h required 1 pulse code=7", kv_cnt - kv0, key_code);
        end
        total++;
        if (obs !== model_vec()) begin bad++; $display("FAIL bounce_digits: got %h required %h", obs, model_vec()); end
    endtask

    task automatic test_done_digit();
        bit got;
        logic [3:0] kc;
        press_key(10, 2, got, kc);
        press_key(15, 2, got, kc);
        total++;
        if (result_valid !== 1'b1 || obs !== model_vec()) begin
            bad++; $display("FAIL done_entry: got %h required %h", obs, model_vec());
        end
        press_key(9, 2, got, kc);
        total++;
        if (obs !== {8'h00, 4'd9, 12'h000, 1'b0, 1'b0} || obs !== model_vec()) begin
            bad++; $display("FAIL done_digit_restart: got %h required %h", obs, {8'h00, 4'd9, 14'h0});
        end
        press_key(14, 2, got, kc);
        total++;
        if (obs !== 26'd0 || obs !== model_vec()) begin bad++; $display("FAIL star_clear: got %h required 0", obs); end
    endtask

    task automatic test_multi_row();
        int kv0;
        bit got;
        kv0 = kv_cnt;
        got = 1'b0;
        keys[1] = 1'b1; keys[5] = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) got = 1'b1;
        end
        total++;
        if (!got || key_code !== 4'd2) begin
            bad++; $display("FAIL multi_row_priority: got valid=%b code=%h required code=2", got, key_code);
        end
        repeat (3) @(negedge clk);
        keys[1] = 1'b0; keys[5] = 1'b0;
        repeat (30) @(negedge clk);
        model_key(2);
        total++;
        if (kv_cnt - kv0 != 1 || obs !== model_vec()) begin
            bad++; $display("FAIL multi_row_result: got %0d pulses %h required 1 pulse %h", kv_cnt - kv0, obs, model_vec());
        end
    endtask

    task automatic test_random();
        bit got;
        logic [3:0] kc;
        int sel, code;
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 12)      code = int'($urandom_range(0, 9));
            else if (sel < 15) code = 10;
            else if (sel < 18) code = 15;
            else if (sel < 19) code = 14;
            else               code = int'($urandom_range(0, 15));
            press_key(code, int'($urandom_range(0, 10)), got, kc);
            total++;
            if (!got || kc !== 4'(code) || obs !== model_vec()) begin
                bad++; $display("FAIL random[%0d] key %0d: got valid=%b code=%h out=%h required out=%h",
                                i, code, got, kc, obs, model_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int kv0;
        bit got, ok;
        logic [3:0] kc;
        press_key(14, 1, got, kc);
        press_key(3, 1, got, kc);
        kv0 = kv_cnt;
        wait_col0_start(ok);
        keys[0] = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        total++;
        if (!ok || obs !== 26'd0 || col_out !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0) begin
            bad++; $display("FAIL reset_mid_outputs: got %h col=%b kv=%b code=%h required 0 col=1110",
                            obs, col_out, key_valid, key_code);
        end
        keys[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (col_out !== 4'b1110) begin bad++; $display("FAIL reset_mid_col0: got %b required 1110", col_out); end
        repeat (4) @(negedge clk);
        total++;
        if (col_out !== 4'b1101) begin bad++; $display("FAIL reset_mid_col1: got %b required 1101", col_out); end
        repeat (20) @(negedge clk);
        total++;
        if (kv_cnt != kv0 || obs !== model_vec()) begin
            bad++; $display("FAIL reset_mid_no_key: got %0d pulses required 0", kv_cnt - kv0);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_sequence();
        test_bounce();
        test_done_digit();
        test_multi_row();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
